// File: rtl/jtopl_pg_sched.sv
// Phase-generator sequencer: walks the operator slots round-robin, computes each slot's
// phase increment from its frequency settings and advances a per-slot phase accumulator.
module jtopl_pg_sched #(
    parameter int unsigned SLOTS = 18,
    parameter int unsigned PHW   = 19
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    output logic [4:0] slot,
    input  logic [9:0] fnum,
    input  logic [2:0] block,
    input  logic [3:0] mult,
    input  logic       keyon,
    input  logic [3:0] pm_offset,
    output logic       zero,
    output logic [4:0] ph_slot,
    output logic [9:0] phase_out,
    output logic       ph_valid
);

    logic [4:0]     r_slot;
    logic           r_zero;
    logic [SLOTS-1:0] r_hist;
    logic [PHW-1:0] r_acc [SLOTS];

    logic           r_s1_valid;
    logic [4:0]     r_s1_slot;
    logic [PHW-1:0] r_s1_inc;
    logic           r_s1_edge;

    logic [4:0]     r_ph_slot;
    logic [9:0]     r_phase;
    logic           r_ph_valid;

    logic [4:0]     w_slot_nxt;
    logic [16:0]    w_freq_raw;
    logic [16:0]    w_freq_sh;
    logic [15:0]    w_pure;
    logic [4:0]     w_m2;
    logic [20:0]    w_prod;
    logic [20:0]    w_prod_half;
    logic [PHW-1:0] w_inc;
    logic           w_edge;
    logic [PHW-1:0] w_acc_nxt;

    assign w_slot_nxt = (r_slot == 5'(SLOTS - 1)) ? 5'd0 : r_slot + 5'd1;

    // Negative PM offsets wrap modulo 2^17 before the octave shift.
    assign w_freq_raw = {7'd0, fnum} + {{13{pm_offset[3]}}, pm_offset};
    assign w_freq_sh  = w_freq_raw << block;
    assign w_pure     = w_freq_sh[16:1];

    always_comb begin
        w_m2 = 5'd1;
        case (mult)
            4'd0:  w_m2 = 5'd1;
            4'd1:  w_m2 = 5'd2;
            4'd2:  w_m2 = 5'd4;
            4'd3:  w_m2 = 5'd6;
            4'd4:  w_m2 = 5'd8;
            4'd5:  w_m2 = 5'd10;
            4'd6:  w_m2 = 5'd12;
            4'd7:  w_m2 = 5'd14;
            4'd8:  w_m2 = 5'd16;
            4'd9:  w_m2 = 5'd18;
            4'd10: w_m2 = 5'd20;
            4'd11: w_m2 = 5'd20;
            4'd12: w_m2 = 5'd24;
            4'd13: w_m2 = 5'd24;
            4'd14: w_m2 = 5'd30;
            4'd15: w_m2 = 5'd30;
            default: w_m2 = 5'd1;
        endcase
    end

    assign w_prod      = {5'd0, w_pure} * {16'd0, w_m2};
    assign w_prod_half = w_prod >> 1;
    assign w_inc       = w_prod_half[PHW-1:0];
    assign w_edge      = keyon & ~r_hist[r_slot];
    assign w_acc_nxt   = r_s1_edge ? '0 : r_acc[r_s1_slot] + r_s1_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot     <= 5'd0;
            r_zero     <= 1'b0;
            r_hist     <= '0;
            r_s1_valid <= 1'b0;
            r_s1_slot  <= 5'd0;
            r_s1_inc   <= '0;
            r_s1_edge  <= 1'b0;
            r_ph_slot  <= 5'd0;
            r_phase    <= 10'd0;
            r_ph_valid <= 1'b0;
            for (int i = 0; i < SLOTS; i++) r_acc[i] <= '0;
        end else if (cen) begin
            r_slot         <= w_slot_nxt;
            r_zero         <= (w_slot_nxt == 5'd0);
            r_hist[r_slot] <= keyon;
            r_s1_valid     <= 1'b1;
            r_s1_slot      <= r_slot;
            r_s1_inc       <= w_inc;
            r_s1_edge      <= w_edge;
            r_ph_valid     <= r_s1_valid;
            if (r_s1_valid) begin
                r_acc[r_s1_slot] <= w_acc_nxt;
                r_phase          <= w_acc_nxt[PHW-1 -: 10];
                r_ph_slot        <= r_s1_slot;
            end
        end
    end

    assign slot      = r_slot;
    assign zero      = r_zero;
    assign ph_slot   = r_ph_slot;
    assign phase_out = r_phase;
    assign ph_valid  = r_ph_valid;

endmodule

// File: tb/tb_jtopl_pg_sched.sv
// Directed bench for jtopl_pg_sched: increment vectors, slot sequencing, key-on reset,
// mid-frame reset and clock-enable throttling.
module tb_jtopl_pg_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b0;
    logic [4:0] slot;
    logic [9:0] fnum = 10'd0;
    logic [2:0] block = 3'd0;
    logic [3:0] mult = 4'd0;
    logic       keyon;
    logic [3:0] pm_offset = 4'd0;
    logic       zero;
    logic [4:0] ph_slot;
    logic [9:0] phase_out;
    logic       ph_valid;
    logic       kon5 = 1'b0;

    int total = 0;
    int bad = 0;

    assign keyon = (slot == 5'd5) ? kon5 : 1'b0;

    always #5 clk = ~clk;

    jtopl_pg_sched #(.SLOTS(18), .PHW(19)) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .slot      (slot),
        .fnum      (fnum),
        .block     (block),
        .mult      (mult),
        .keyon     (keyon),
        .pm_offset (pm_offset),
        .zero      (zero),
        .ph_slot   (ph_slot),
        .phase_out (phase_out),
        .ph_valid  (ph_valid)
    );

    typedef struct {
        logic [9:0] fnum;
        logic [2:0] blk;
        logic [3:0] mult;
        logic [3:0] pm;
        int         v;
        logic [9:0] exp1;
        logic [9:0] expv;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_in(input logic [9:0] f, input logic [2:0] b, input logic [3:0] m,
                          input logic [3:0] p);
        fnum = f;
        block = b;
        mult = m;
        pm_offset = p;
    endtask

    // Starts from reset state with fnum=0x200/block=4/mult=1 (inc 0x1000 on every slot).
    // cen is high one cycle in 'div'; every cycle the outputs must match the count of cen edges.
    task automatic run_seq(input string nm, input int div, input int cycles);
        int n = 0;
        int k;
        for (int c = 0; c < cycles; c++) begin
            cen = ((c % div) == 0);
            tick();
            if (cen) n++;
            chk({nm, " slot"}, int'(slot), n % 18);
            chk({nm, " zero"}, int'(zero), int'(n > 0 && (n % 18) == 0));
            chk({nm, " valid"}, int'(ph_valid), int'(n >= 2));
            if (n >= 2) begin
                k = n - 2;
                chk({nm, " ph_slot"}, int'(ph_slot), k % 18);
                chk({nm, " phase"}, int'(phase_out), 8 * (k / 18 + 1));
            end
        end
        cen = 1'b0;
    endtask

    initial begin
        int vis;
        int v5;
        int guard;

        //           fnum    blk   mult   pm     v    exp1     expv
        vt[0] = '{10'h200, 3'd4, 4'd1,  4'h0, 128, 10'h008, 10'h000};
        vt[1] = '{10'h000, 3'd0, 4'd1,  4'hF, 8,   10'h07F, 10'h3FF};
        vt[2] = '{10'h100, 3'd1, 4'd0,  4'h0, 12,  10'h000, 10'h003};
        vt[3] = '{10'h100, 3'd1, 4'd15, 4'h0, 4,   10'h007, 10'h01E};
        vt[4] = '{10'h0FF, 3'd2, 4'd2,  4'h1, 10,  10'h002, 10'h014};
        vt[5] = '{10'h3FF, 3'd7, 4'd10, 4'h0, 2,   10'h0FE, 10'h1FD};
        vt[6] = '{10'h010, 3'd3, 4'd4,  4'h8, 16,  10'h000, 10'h004};
        vt[7] = '{10'h000, 3'd1, 4'd3,  4'hF, 2,   10'h17F, 10'h2FF};

        do_reset();
        chk("rst slot", int'(slot), 0);
        chk("rst zero", int'(zero), 0);
        chk("rst valid", int'(ph_valid), 0);
        chk("rst phase", int'(phase_out), 0);
        chk("rst ph_slot", int'(ph_slot), 0);

        // Increment vectors: count slot-0 results, check first and v-th phase.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            set_in(vt[i].fnum, vt[i].blk, vt[i].mult, vt[i].pm);
            cen = 1'b1;
            vis = 0;
            for (int c = 0; c < 18 * (vt[i].v + 2) + 10; c++) begin
                tick();
                if (ph_valid && ph_slot == 5'd0) begin
                    vis++;
                    if (vis == 1) chk($sformatf("vec%0d first", i), int'(phase_out),
                                      int'(vt[i].exp1));
                    if (vis == vt[i].v) begin
                        chk($sformatf("vec%0d visit%0d", i, vt[i].v), int'(phase_out),
                            int'(vt[i].expv));
                        break;
                    end
                end
            end
            if (vis < vt[i].v) chk($sformatf("vec%0d timeout", i), vis, vt[i].v);
            cen = 1'b0;
        end

        set_in(10'h200, 3'd4, 4'd1, 4'h0);

        do_reset();
        run_seq("cen_hi", 1, 40);

        do_reset();
        run_seq("cen_1of3", 3, 150);

        // Key-on rising edge on slot 5 after three visits.
        do_reset();
        kon5 = 1'b0;
        cen = 1'b1;
        v5 = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (ph_valid && ph_slot == 5'd5) begin
                v5++;
                if (v5 == 3) begin
                    chk("kon pre", int'(phase_out), 10'h018);
                    kon5 = 1'b1;
                end
                if (v5 == 4) chk("kon edge", int'(phase_out), 10'h000);
                if (v5 == 5) chk("kon held1", int'(phase_out), 10'h008);
                if (v5 == 6) begin
                    chk("kon held2", int'(phase_out), 10'h010);
                    break;
                end
            end
        end
        if (v5 < 6) chk("kon timeout", v5, 6);
        kon5 = 1'b0;

        // Reset while slot 9 is being fetched, then restart from phase 0.
        guard = 0;
        while (slot != 5'd9 && guard < 40) begin
            tick();
            guard++;
        end
        chk("mid slot9 reached", int'(slot), 9);
        cen = 1'b0;
        do_reset();
        chk("mid slot", int'(slot), 0);
        chk("mid valid", int'(ph_valid), 0);
        chk("mid phase", int'(phase_out), 0);
        chk("mid zero", int'(zero), 0);
        run_seq("restart", 1, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
